// File: rtl/tuner_pkg.sv
// Shared types for the tuner datapath: bin index encoding and the
// change-event payload passed to the display stage.
package tuner_pkg;
   localparam int NUM_BINS = 7;

   typedef logic [2:0] note_idx_t;

   localparam note_idx_t NO_PITCH = 3'd7;

   typedef struct packed {
      note_idx_t note;
      logic      locked;
   } note_evt_t;
endpackage

// File: rtl/note_stabilizer_sat_counter.sv
// Saturating up-counter with clear (highest priority), set-to-one and increment.
// Used for both the run-length counter and the idle timer.
module sat_counter #(
   parameter int WIDTH = 4,
   parameter int MAX   = 15
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clr_i,
   input  logic             set_one_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (set_one_i) begin
         cnt_d = WIDTH'(1);
      end else if (inc_i && (cnt_q != MAX_V)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/note_stabilizer.sv
// Debounces the stream of winning bin indices into a committed note and
// reports each commit or lock loss through a one-deep event slot.
module note_stabilizer
   import tuner_pkg::*;
#(
   parameter int STABLE_COUNT_P = 4,
   parameter int HOLD_CYCLES_P  = 1000000
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       valid_i,
   input  logic [2:0] index_i,
   output logic       ready_o,
   output logic [2:0] note_o,
   output logic       locked_o,
   output logic       evt_valid_o,
   input  logic       evt_ready_i,
   output logic [2:0] evt_note_o,
   output logic       evt_locked_o
);
   localparam int CNT_W  = $clog2(STABLE_COUNT_P + 1);
   localparam int IDLE_W = $clog2(HOLD_CYCLES_P + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_COUNT_P);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(HOLD_CYCLES_P);

   note_idx_t   note_q, note_d;
   note_idx_t   cand_q, cand_d;
   logic        locked_q, locked_d;
   logic        evt_valid_q, evt_valid_d;
   note_evt_t   evt_q, evt_d;

   logic [CNT_W-1:0]  cnt;
   logic [IDLE_W-1:0] idle;

   logic accept, pitch, same, hits_max, commit, timeout;
   logic cnt_clr, cnt_set, cnt_inc, idle_clr, idle_inc;

   always_comb begin
      accept   = valid_i & ~evt_valid_q;
      pitch    = (index_i != NO_PITCH);
      same     = (cnt != '0) && (index_i == cand_q);
      // Count after this sample reaches the threshold (counter saturates at it).
      hits_max = same ? (cnt >= (CNT_MAX - CNT_W'(1))) : (STABLE_COUNT_P == 1);
      commit   = accept & pitch & hits_max & (~locked_q | (index_i != note_q));
      timeout  = ~accept & (idle == IDLE_MAX) & locked_q & ~evt_valid_q;

      cnt_clr  = (accept & ~pitch) | timeout;
      cnt_set  = accept & pitch & ~same;
      cnt_inc  = accept & pitch & same;
      idle_clr = accept & pitch;
      idle_inc = ~accept;

      note_d      = note_q;
      cand_d      = cand_q;
      locked_d    = locked_q;
      evt_valid_d = evt_valid_q;
      evt_d       = evt_q;

      if (cnt_set) begin
         cand_d = index_i;
      end
      if (evt_valid_q && evt_ready_i) begin
         evt_valid_d = 1'b0;
         evt_d       = '0;
      end
      if (commit) begin
         note_d      = index_i;
         locked_d    = 1'b1;
         evt_valid_d = 1'b1;
         evt_d       = '{note: index_i, locked: 1'b1};
      end else if (timeout) begin
         note_d      = '0;
         locked_d    = 1'b0;
         evt_valid_d = 1'b1;
         evt_d       = '{note: '0, locked: 1'b0};
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         note_q      <= '0;
         cand_q      <= '0;
         locked_q    <= 1'b0;
         evt_valid_q <= 1'b0;
         evt_q       <= '0;
      end else begin
         note_q      <= note_d;
         cand_q      <= cand_d;
         locked_q    <= locked_d;
         evt_valid_q <= evt_valid_d;
         evt_q       <= evt_d;
      end
   end

   sat_counter #(.WIDTH(CNT_W), .MAX(STABLE_COUNT_P)) u_cnt (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .clr_i     (cnt_clr),
      .set_one_i (cnt_set),
      .inc_i     (cnt_inc),
      .cnt_o     (cnt)
   );

   sat_counter #(.WIDTH(IDLE_W), .MAX(HOLD_CYCLES_P)) u_idle (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .clr_i     (idle_clr),
      .set_one_i (1'b0),
      .inc_i     (idle_inc),
      .cnt_o     (idle)
   );

   assign ready_o      = ~evt_valid_q;
   assign note_o       = note_q;
   assign locked_o     = locked_q;
   assign evt_valid_o  = evt_valid_q;
   assign evt_note_o   = evt_q.note;
   assign evt_locked_o = evt_q.locked;
endmodule

// File: tb/tb_note_stabilizer.sv
// Directed scenarios plus randomized traffic for note_stabilizer, checked
// every cycle against a run-length/idle-time model of the commit rules.
module tb_note_stabilizer;
   import tuner_pkg::*;

   localparam int STABLE = 4;
   localparam int HOLD   = 16;

   logic       clk = 1'b0;
   logic       reset_i = 1'b1;
   logic       valid_i = 1'b0;
   logic [2:0] index_i = 3'd0;
   logic       evt_ready_i = 1'b1;
   logic       ready_o, locked_o, evt_valid_o, evt_locked_o;
   logic [2:0] note_o, evt_note_o;

   int n_checks = 0;
   int n_fail   = 0;

   note_stabilizer #(.STABLE_COUNT_P(STABLE), .HOLD_CYCLES_P(HOLD)) dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .valid_i      (valid_i),
      .index_i      (index_i),
      .ready_o      (ready_o),
      .note_o       (note_o),
      .locked_o     (locked_o),
      .evt_valid_o  (evt_valid_o),
      .evt_ready_i  (evt_ready_i),
      .evt_note_o   (evt_note_o),
      .evt_locked_o (evt_locked_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: length of the current run of identical pitches and
   // the number of cycles since the last accepted pitch, both unbounded.
   int m_note = 0, m_locked = 0, m_evt_valid = 0, m_evt_note = 0, m_evt_locked = 0;
   int run_note = 0, run_len = 0, idle = 0;
   bit m_acc, m_cons, m_commit, m_tmo;

   always @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         m_note = 0; m_locked = 0; m_evt_valid = 0; m_evt_note = 0; m_evt_locked = 0;
         run_note = 0; run_len = 0; idle = 0;
      end else begin
         m_acc    = valid_i && (m_evt_valid == 0);
         m_cons   = (m_evt_valid != 0) && evt_ready_i;
         m_commit = 1'b0;
         m_tmo    = 1'b0;
         if (m_acc && index_i != 3'd7) begin
            idle = 0;
            if (run_len > 0 && int'(index_i) == run_note) run_len++;
            else begin
               run_note = int'(index_i);
               run_len  = 1;
            end
            m_commit = (run_len >= STABLE) && (m_locked == 0 || run_note != m_note);
         end else if (m_acc) begin
            run_len = 0;
         end else begin
            m_tmo = (idle >= HOLD) && (m_locked != 0) && (m_evt_valid == 0);
            idle++;
            if (m_tmo) run_len = 0;
         end
         if (m_cons) m_evt_valid = 0;
         if (m_commit) begin
            m_note = run_note; m_locked = 1;
            m_evt_valid = 1; m_evt_note = run_note; m_evt_locked = 1;
         end else if (m_tmo) begin
            m_note = 0; m_locked = 0;
            m_evt_valid = 1; m_evt_note = 0; m_evt_locked = 0;
         end
      end
   end

   always @(negedge clk) begin
      chk("ready_o", 32'(ready_o), 32'(m_evt_valid == 0));
      chk("note_o", 32'(note_o), m_note);
      chk("locked_o", 32'(locked_o), m_locked);
      chk("evt_valid_o", 32'(evt_valid_o), m_evt_valid);
      if (m_evt_valid != 0) begin
         chk("evt_note_o", 32'(evt_note_o), m_evt_note);
         chk("evt_locked_o", 32'(evt_locked_o), m_evt_locked);
      end
   end

   task automatic send(input logic [2:0] idx);
      bit done = 1'b0;
      valid_i = 1'b1;
      index_i = idx;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (ready_o) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: got no accept for index %0d, required accept within 200 cycles", idx);
      end else begin
         $display("send index=%0d note=%0d locked=%0d evt_valid=%0d", idx, note_o, locked_o, evt_valid_o);
      end
   endtask

   task automatic idle_cycles(input int n);
      valid_i = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_note"}, 32'(note_o), 0);
      chk({tag, "_locked"}, 32'(locked_o), 0);
      chk({tag, "_evt_valid"}, 32'(evt_valid_o), 0);
      chk({tag, "_evt_note"}, 32'(evt_note_o), 0);
      chk({tag, "_evt_locked"}, 32'(evt_locked_o), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int seq2 [7] = '{3, 3, 5, 3, 3, 3, 3};
      int seq5 [5] = '{4, 4, 7, 4, 4};
      int edges;
      int mode, pv;
      logic [2:0] last_idx;

      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      chk("reset_ready", 32'(ready_o), 1);
      reset_i = 1'b0;

      // First commit on 3
      evt_ready_i = 1'b1;
      repeat (4) send(3'd3);
      valid_i = 1'b0;
      chk("t1_evt_valid", 32'(evt_valid_o), 1);
      chk("t1_evt_note", 32'(evt_note_o), 3);
      chk("t1_evt_locked", 32'(evt_locked_o), 1);
      chk("t1_note", 32'(note_o), 3);
      chk("t1_locked", 32'(locked_o), 1);
      idle_cycles(1);
      chk("t1_evt_cleared", 32'(evt_valid_o), 0);

      // Re-confirmation and a stray 5 produce no events
      foreach (seq2[i]) begin
         send(3'(seq2[i]));
         chk("t2_no_evt", 32'(evt_valid_o), 0);
      end
      valid_i = 1'b0;
      chk("t2_note", 32'(note_o), 3);

      // Back-pressured event holds and stalls input
      evt_ready_i = 1'b0;
      repeat (4) send(3'd5);
      valid_i = 1'b0;
      chk("t3_evt_note", 32'(evt_note_o), 5);
      chk("t3_ready", 32'(ready_o), 0);
      idle_cycles(3);
      chk("t3_evt_held", 32'(evt_valid_o), 1);
      chk("t3_evt_note_held", 32'(evt_note_o), 5);
      chk("t3_ready_held", 32'(ready_o), 0);
      evt_ready_i = 1'b1;
      send(3'd6);
      valid_i = 1'b0;
      chk("t3_after_evt", 32'(evt_valid_o), 0);
      chk("t3_note", 32'(note_o), 5);

      // Lock on 2 then let the hold timer expire
      repeat (4) send(3'd2);
      valid_i = 1'b0;
      chk("t4_evt_note", 32'(evt_note_o), 2);
      edges = 0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         #1;
         edges++;
         if (evt_valid_o && !evt_locked_o) break;
      end
      chk("t4_timeout_edges", edges, 17);
      chk("t4_evt_note", 32'(evt_note_o), 0);
      chk("t4_locked", 32'(locked_o), 0);
      chk("t4_note", 32'(note_o), 0);

      // No-pitch sample breaks the run
      foreach (seq5[i]) begin
         send(3'(seq5[i]));
         chk("t5_no_evt", 32'(evt_valid_o), 0);
      end
      chk("t5_unlocked", 32'(locked_o), 0);
      send(3'd4);
      chk("t5_no_evt_yet", 32'(evt_valid_o), 0);
      send(3'd4);
      valid_i = 1'b0;
      chk("t5_evt_valid", 32'(evt_valid_o), 1);
      chk("t5_evt_note", 32'(evt_note_o), 4);
      chk("t5_evt_locked", 32'(evt_locked_o), 1);

      // Asynchronous reset mid-count
      send(3'd1);
      send(3'd1);
      valid_i = 1'b0;
      #2 reset_i = 1'b1;
      #1 chk_all_zero("t6a");
      @(posedge clk);
      #1 reset_i = 1'b0;
      chk("t6a_ready", 32'(ready_o), 1);

      // Asynchronous reset with an event pending
      evt_ready_i = 1'b0;
      repeat (4) send(3'd6);
      valid_i = 1'b0;
      chk("t6b_pending", 32'(evt_valid_o), 1);
      #2 reset_i = 1'b1;
      #1 chk_all_zero("t6b");
      @(posedge clk);
      #1 reset_i = 1'b0;
      chk("t6b_ready", 32'(ready_o), 1);
      evt_ready_i = 1'b1;

      // Randomized traffic in bursts: busy, sparse and silent phases
      last_idx = 3'd0;
      pv = 80;
      for (int c = 0; c < 4000; c++) begin
         if (c % 64 == 0) begin
            mode = int'($urandom_range(0, 2));
            pv = (mode == 0) ? 85 : (mode == 1) ? 0 : 50;
         end
         @(posedge clk);
         #1;
         valid_i = ($urandom_range(0, 99) < pv);
         if ($urandom_range(0, 3) == 0) last_idx = 3'($urandom_range(0, 7));
         index_i = last_idx;
         evt_ready_i = ($urandom_range(0, 3) != 0);
      end
      valid_i = 1'b0;
      evt_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
